// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm ring controller: state encoding and default timing.
package alarm_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRing   = 2'd1,
    StSnooze = 2'd2
  } alarm_state_e;

  localparam int unsigned RingSecondsDefault   = 60;
  localparam int unsigned SnoozeSecondsDefault = 300;
  localparam int unsigned MaxSnoozeDefault     = 3;

  localparam int unsigned SecCntWidth = 9;
  localparam int unsigned SnzCntWidth = 8;

endpackage

// File: rtl/alarm_ring_if.sv
// Time/alarm inputs, keys and annunciator outputs of the alarm ring controller.
interface alarm_ring_if;

  logic       second_tick;
  logic [7:0] hour_data;
  logic [7:0] minute_data;
  logic [7:0] second_data;
  logic [7:0] alarm_hour;
  logic [7:0] alarm_minute;
  logic       alarm_enable;
  logic       stop_key;
  logic       snooze_key;
  logic       buzzer;
  logic       ringing;
  logic       snooze_active;

  modport master (
    output second_tick, hour_data, minute_data, second_data,
    output alarm_hour, alarm_minute, alarm_enable, stop_key, snooze_key,
    input  buzzer, ringing, snooze_active
  );

  modport slave (
    input  second_tick, hour_data, minute_data, second_data,
    input  alarm_hour, alarm_minute, alarm_enable, stop_key, snooze_key,
    output buzzer, ringing, snooze_active
  );

endinterface

// File: rtl/alarm_sec_counter.sv
// Saturating seconds counter; clear has priority over tick.
module alarm_sec_counter #(
  parameter int unsigned Width = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_d;

  always_comb begin
    count_d = count;
    if (clear) begin
      count_d = '0;
    end else if (tick && (count != {Width{1'b1}})) begin
      count_d = count + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/alarm_ring.sv
// Alarm event controller: IDLE -> RING on time match, with snooze, stop and auto-stop.
module alarm_ring
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECONDS   = RingSecondsDefault,
  parameter int unsigned SNOOZE_SECONDS = SnoozeSecondsDefault,
  parameter int unsigned MAX_SNOOZE     = MaxSnoozeDefault
) (
  input  logic        clock,
  input  logic        reset,
  alarm_ring_if.slave bus
);

  localparam logic [SecCntWidth-1:0] RingLast   = SecCntWidth'(RING_SECONDS - 1);
  localparam logic [SecCntWidth-1:0] SnoozeLast = SecCntWidth'(SNOOZE_SECONDS - 1);
  localparam logic [SnzCntWidth-1:0] MaxSnz     = SnzCntWidth'(MAX_SNOOZE);

  alarm_state_e           state_q, state_d;
  logic [SnzCntWidth-1:0] snz_cnt_q, snz_cnt_d;
  logic                   beep_q, beep_d;
  logic                   sec_clear, sec_tick;
  logic [SecCntWidth-1:0] sec_count;
  logic                   match;

  // Raw byte compare of the BCD fields; only meaningful on a tick clock.
  assign match = bus.alarm_enable &&
                 (bus.hour_data == bus.alarm_hour) &&
                 (bus.minute_data == bus.alarm_minute) &&
                 (bus.second_data == 8'h00);

  alarm_sec_counter #(
    .Width (SecCntWidth)
  ) u_sec_counter (
    .clock (clock),
    .reset (reset),
    .clear (sec_clear),
    .tick  (sec_tick),
    .count (sec_count)
  );

  always_comb begin
    state_d   = state_q;
    snz_cnt_d = snz_cnt_q;
    beep_d    = beep_q;
    sec_clear = 1'b0;
    sec_tick  = 1'b0;
    if (!bus.alarm_enable) begin
      state_d   = StIdle;
      snz_cnt_d = '0;
      beep_d    = 1'b0;
      sec_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          sec_clear = 1'b1;
          beep_d    = 1'b0;
          if (bus.second_tick && match) begin
            state_d   = StRing;
            snz_cnt_d = '0;
            beep_d    = 1'b1;
          end
        end
        StRing: begin
          // Stop outranks snooze when both keys arrive together.
          if (bus.stop_key) begin
            state_d   = StIdle;
            sec_clear = 1'b1;
            beep_d    = 1'b0;
          end else if (bus.snooze_key && (snz_cnt_q < MaxSnz)) begin
            state_d   = StSnooze;
            sec_clear = 1'b1;
            snz_cnt_d = snz_cnt_q + 1'b1;
            beep_d    = 1'b0;
          end else if (bus.second_tick) begin
            if (sec_count == RingLast) begin
              state_d   = StIdle;
              sec_clear = 1'b1;
              beep_d    = 1'b0;
            end else begin
              sec_tick = 1'b1;
              beep_d   = ~beep_q;
            end
          end
        end
        StSnooze: begin
          if (bus.stop_key) begin
            state_d   = StIdle;
            sec_clear = 1'b1;
          end else if (bus.second_tick) begin
            if (sec_count == SnoozeLast) begin
              state_d   = StRing;
              sec_clear = 1'b1;
              beep_d    = 1'b1;
            end else begin
              sec_tick = 1'b1;
            end
          end
        end
        default: begin
          state_d   = StIdle;
          snz_cnt_d = '0;
          beep_d    = 1'b0;
          sec_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      snz_cnt_q <= '0;
      beep_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      snz_cnt_q <= snz_cnt_d;
      beep_q    <= beep_d;
    end
  end

  // Decoded from registered state only, so reset silences the outputs at once.
  assign bus.ringing       = (state_q == StRing);
  assign bus.snooze_active = (state_q == StSnooze);
  assign bus.buzzer        = (state_q == StRing) && beep_q;

endmodule

// File: tb/tb_alarm_ring.sv
// Directed bench for alarm_ring: vector table plus multi-cycle ring/snooze/reset sequences.
module tb_alarm_ring;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct {
    logic       tick, en, stop, snz;
    logic [7:0] hr, mn, sc;
    logic       ring, snzact, buzz;
  } vec_t;

  logic clock;
  logic reset;
  int   nvec;
  int   nfail;

  alarm_ring_if bus ();

  alarm_ring u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check3(input string name, input logic r, input logic s, input logic b);
    check({name, " ringing"}, bus.ringing, r);
    check({name, " snooze_active"}, bus.snooze_active, s);
    check({name, " buzzer"}, bus.buzzer, b);
  endtask

  // Drive one clock worth of inputs, then sample 1 ns after the rising edge.
  task automatic step(input logic tick, input logic en, input logic stp, input logic snz,
                      input logic [7:0] hr, input logic [7:0] mn, input logic [7:0] sc);
    bus.second_tick  = tick;
    bus.alarm_enable = en;
    bus.stop_key     = stp;
    bus.snooze_key   = snz;
    bus.hour_data    = hr;
    bus.minute_data  = mn;
    bus.second_data  = sc;
    @(posedge clock);
    #1;
  endtask

  task automatic trigger();
    step(H, H, L, L, 8'h07, 8'h29, 8'h59);
    step(H, H, L, L, 8'h07, 8'h30, 8'h00);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) step(H, H, L, L, 8'h07, 8'h30, 8'h01);
  endtask

  vec_t vecs[17];

  initial begin
    nvec  = 0;
    nfail = 0;

    vecs[0]  = '{H, H, L, L, 8'h07, 8'h29, 8'h59, L, L, L};
    vecs[1]  = '{H, H, L, L, 8'h07, 8'h30, 8'h00, H, L, H};
    vecs[2]  = '{L, H, L, L, 8'h07, 8'h30, 8'h00, H, L, H};
    vecs[3]  = '{H, H, L, L, 8'h07, 8'h30, 8'h01, H, L, L};
    vecs[4]  = '{H, H, L, L, 8'h07, 8'h30, 8'h02, H, L, H};
    vecs[5]  = '{L, H, H, H, 8'h07, 8'h30, 8'h02, L, L, L};
    vecs[6]  = '{H, H, L, L, 8'h07, 8'h30, 8'h00, H, L, H};
    vecs[7]  = '{L, H, L, H, 8'h07, 8'h30, 8'h00, L, H, L};
    vecs[8]  = '{H, H, L, L, 8'h07, 8'h30, 8'h00, L, H, L};
    vecs[9]  = '{L, H, L, H, 8'h07, 8'h30, 8'h00, L, H, L};
    vecs[10] = '{L, H, H, L, 8'h07, 8'h30, 8'h00, L, L, L};
    vecs[11] = '{H, L, L, L, 8'h07, 8'h30, 8'h00, L, L, L};
    vecs[12] = '{L, H, L, L, 8'h07, 8'h30, 8'h00, L, L, L};
    vecs[13] = '{H, H, L, L, 8'h07, 8'h30, 8'h01, L, L, L};
    vecs[14] = '{H, H, L, L, 8'h08, 8'h30, 8'h00, L, L, L};
    vecs[15] = '{H, H, L, L, 8'h07, 8'h30, 8'h00, H, L, H};
    vecs[16] = '{L, L, L, L, 8'h07, 8'h30, 8'h00, L, L, L};

    bus.alarm_hour   = 8'h07;
    bus.alarm_minute = 8'h30;
    bus.second_tick  = L;
    bus.alarm_enable = H;
    bus.stop_key     = L;
    bus.snooze_key   = L;
    bus.hour_data    = 8'h07;
    bus.minute_data  = 8'h30;
    bus.second_data  = 8'h00;

    // Held in reset with a live match presented: must stay silent.
    reset = 1'b1;
    bus.second_tick = H;
    repeat (2) @(posedge clock);
    #1;
    check3("reset", L, L, L);
    @(negedge clock);
    reset = 1'b0;

    step(L, H, L, L, 8'h07, 8'h29, 8'h59);
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].tick, vecs[i].en, vecs[i].stop, vecs[i].snz,
           vecs[i].hr, vecs[i].mn, vecs[i].sc);
      check3($sformatf("vec%0d", i), vecs[i].ring, vecs[i].snzact, vecs[i].buzz);
    end

    // Unattended ring: beeps alternate and auto-stop lands on the 60th tick.
    trigger();
    check3("ring_entry", H, L, H);
    for (int i = 1; i <= 60; i++) begin
      tick_n(1);
      if (i < 60) check($sformatf("ring_t%0d buzzer", i), bus.buzzer, (i % 2) == 0);
      if (i == 59) check("ring_t59 ringing", bus.ringing, H);
      if (i == 60) check3("ring_t60", L, L, L);
    end

    // Three honoured snoozes of 300 ticks each, then a fourth is ignored.
    trigger();
    check3("snz_entry", H, L, H);
    for (int s = 1; s <= 3; s++) begin
      step(L, H, L, H, 8'h07, 8'h30, 8'h01);
      check3($sformatf("snz%0d start", s), L, H, L);
      tick_n(299);
      check3($sformatf("snz%0d t299", s), L, H, L);
      tick_n(1);
      check3($sformatf("snz%0d t300", s), H, L, H);
    end
    step(L, H, L, H, 8'h07, 8'h30, 8'h01);
    check3("snz4 ignored", H, L, H);
    step(L, H, H, L, 8'h07, 8'h30, 8'h01);
    check3("snz stop", L, L, L);

    // Disable during snooze, then a disabled match must not ring.
    trigger();
    step(L, H, L, H, 8'h07, 8'h30, 8'h01);
    tick_n(5);
    check3("dis pre", L, H, L);
    step(L, L, L, L, 8'h07, 8'h30, 8'h01);
    check3("dis idle", L, L, L);
    step(H, L, L, L, 8'h07, 8'h30, 8'h00);
    check3("dis match", L, L, L);
    step(L, H, L, L, 8'h07, 8'h30, 8'h00);
    check3("dis reenable", L, L, L);

    // Asynchronous reset mid-ring silences before the next clock edge.
    trigger();
    check3("arst pre", H, L, H);
    #2 reset = 1'b1;
    #1;
    check3("arst async", L, L, L);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_n(1);
      check3($sformatf("arst idle%0d", i), L, L, L);
    end
    step(H, H, L, L, 8'h07, 8'h30, 8'h00);
    check3("arst rematch", H, L, H);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/alarm_ring.md
ALARM_RING -- requirements
Module: alarm_ring

Interface
REQ-001 Parameter RING_SECONDS, default 60, maximum ring duration in seconds before auto-stop.
REQ-002 Parameter SNOOZE_SECONDS, default 300, snooze interval in seconds.
REQ-003 Parameter MAX_SNOOZE, default 3, snooze presses honoured per alarm event.
REQ-004 clock  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 second_tick  input  1  one-clock pulse, once per second, aligned with the time counter update.
REQ-007 hour_data, minute_data, second_data  input  8 each  current time, two-digit BCD.
REQ-008 alarm_hour, alarm_minute  input  8 each  alarm register contents, two-digit BCD.
REQ-009 alarm_enable  input  1  level; alarm armed when 1.
REQ-010 stop_key  input  1  debounced one-clock pulse; silences the current alarm event.
REQ-011 snooze_key  input  1  debounced one-clock pulse; requests a snooze.
REQ-012 buzzer  output  1  beeper drive.
REQ-013 ringing  output  1  high while in RING.
REQ-014 snooze_active  output  1  high while in SNOOZE.

Function
REQ-015 States: IDLE, RING, SNOOZE; a state change is visible one clock after the causing condition.
REQ-016 Match = alarm_enable AND hour_data==alarm_hour AND minute_data==alarm_minute AND second_data==8'h00, evaluated only on a clock with second_tick=1.
REQ-017 IDLE->RING on match; clear the second counter to 0 and the snooze counter to 0.
REQ-018 RING: the second counter increments on each second_tick; RING->IDLE when the counter reaches RING_SECONDS-1 and second_tick=1.
REQ-019 RING: stop_key=1 -> IDLE.
REQ-020 RING: snooze_key=1 with snooze count < MAX_SNOOZE -> SNOOZE, clear the second counter, and increment the snooze count; at MAX_SNOOZE, snooze_key is ignored.
REQ-021 SNOOZE: the counter increments on each second_tick; SNOOZE->RING when the count reaches SNOOZE_SECONDS-1 and second_tick=1, and clear the counter on entry to RING.
REQ-022 SNOOZE: stop_key=1 -> IDLE; snooze_key ignored.
REQ-023 stop_key and snooze_key in the same clock: stop wins.
REQ-024 alarm_enable=0 in any state -> IDLE on the next clock; counters cleared.
REQ-025 A match in RING or SNOOZE is ignored and does not restart the event.
REQ-026 buzzer = ringing AND beep_phase; beep_phase is set to 1 on entry to RING and toggles on each second_tick in RING (1 s on / 1 s off).
REQ-027 The second counter is 9 bits wide, unsigned, and saturates at 511; it never wraps.
REQ-028 BCD inputs are compared as raw 8-bit values; no BCD-to-binary conversion.

Reset
REQ-029 While reset=1: state IDLE, counters 0, beep_phase 0, buzzer=0, ringing=0, snooze_active=0.
REQ-030 Reset asserted mid-RING or mid-SNOOZE silences the buzzer immediately, without waiting for a clock edge.

Structure
REQ-031 Shared package alarm_pkg holds the state encoding (IDLE=2'd0, RING=2'd1, SNOOZE=2'd2) and the default values of RING_SECONDS, SNOOZE_SECONDS and MAX_SNOOZE.
REQ-032 The second counter is one sub-module, alarm_sec_counter, with ports clear, tick and count, reset by the same asynchronous reset.
REQ-033 All outputs are registered or decoded directly from registered state; no combinational path from a key input to buzzer.

Verification
REQ-034 Alarm 07:30, enable=1, time steps 07:29:59->07:30:00 with tick -> ringing=1 next clock, buzzer=1; buzzer=0 after the next tick.
REQ-035 Ring left alone -> ringing=0 exactly 60 ticks after entry.
REQ-036 Snooze during RING -> snooze_active=1, buzzer=0; after 300 ticks ringing=1; a fourth snooze_key after three snoozes is ignored.
REQ-037 stop_key and snooze_key pulsed in the same clock during RING -> IDLE, snooze_active=0.
REQ-038 alarm_enable=0 during SNOOZE -> IDLE next clock; time returning to 07:30:00 with enable=0 -> no ring.
REQ-039 reset=1 asynchronously mid-RING -> buzzer=0 and ringing=0 before the next clock edge; after release the block stays IDLE until the next match.
